// File: rtl/encoder_scheduler.sv
// Time-multiplexed rate encoder: one shared period-counter/LFSR datapath scans
// NUM_CH binary channels round-robin and streams spike events over valid/ready.
module encoder_scheduler #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2,
    parameter int CNT_W  = 4,
    parameter int N      = 10,
    parameter int M      = 5,
    parameter int WINDOW = 16,
    parameter int TS_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [NUM_CH-1:0] input_bits,
    output logic              busy,
    output logic              done,
    output logic              spike_valid,
    input  logic              spike_ready,
    output logic [CH_W-1:0]   spike_ch,
    output logic [TS_W-1:0]   spike_ts
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [TS_W-1:0]  LAST_TS  = TS_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] THR_ONE  = CNT_W'(M - 1);
    localparam logic [CNT_W-1:0] THR_ZERO = CNT_W'(N - 1);

    state_t            state, state_nxt;
    logic [NUM_CH-1:0] bits_q;
    logic [CNT_W-1:0]  cnt [NUM_CH];
    logic [CH_W-1:0]   ch_idx;
    logic [TS_W-1:0]   ts;
    logic [3:0]        lfsr;

    logic              start_frame;
    logic              do_abort;
    logic              adv;
    logic              frame_end;
    logic              last_ch;
    logic              hit;
    logic [CNT_W-1:0]  cnt_sel;
    logic [CNT_W-1:0]  thr;
    logic [3:0]        lfsr_nxt;

    assign busy     = (state == SCAN);
    assign last_ch  = (ch_idx == LAST_CH);
    assign cnt_sel  = cnt[ch_idx];
    // Threshold jitters down by one on LFSR bit 0; >= keeps a lowered threshold from being skipped.
    assign thr      = (bits_q[ch_idx] ? THR_ONE : THR_ZERO) - CNT_W'(lfsr[0]);
    assign hit      = (cnt_sel >= thr);
    assign lfsr_nxt = {lfsr[2] ^ lfsr[3], lfsr[0], lfsr[1], lfsr[2]};

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        do_abort    = 1'b0;
        adv         = 1'b0;
        frame_end   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_frame = 1'b1;
                    state_nxt   = SCAN;
                end
            end
            SCAN: begin
                // Abort wins over a scan step in the same cycle.
                if (abort) begin
                    do_abort  = 1'b1;
                    state_nxt = IDLE;
                end else if (!spike_valid || spike_ready) begin
                    adv = 1'b1;
                    if (last_ch && (ts == LAST_TS)) begin
                        frame_end = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bits_q      <= '0;
            // NOTE: the counter array is only NUM_CH entries of flops, so it is reset like any register.
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
            ch_idx      <= '0;
            ts          <= '0;
            lfsr        <= 4'b0001;
            done        <= 1'b0;
            spike_valid <= 1'b0;
            spike_ch    <= '0;
            spike_ts    <= '0;
        end else begin
            done <= frame_end;

            if (start_frame) begin
                bits_q <= input_bits;
                for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
                ch_idx <= '0;
                ts     <= '0;
            end

            if (adv) begin
                if (hit) cnt[ch_idx] <= '0;
                else     cnt[ch_idx] <= cnt_sel + CNT_W'(1);
                // The LFSR free-runs across frames, stepping once per completed timestep.
                if (last_ch) begin
                    ch_idx <= '0;
                    ts     <= ts + TS_W'(1);
                    lfsr   <= lfsr_nxt;
                end else begin
                    ch_idx <= ch_idx + CH_W'(1);
                end
            end

            if (do_abort) begin
                spike_valid <= 1'b0;
            end else if (adv && hit) begin
                spike_valid <= 1'b1;
                spike_ch    <= ch_idx;
                spike_ts    <= ts;
            end else if (spike_valid && spike_ready) begin
                spike_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_encoder_scheduler.sv
// Bench for encoder_scheduler: a frame-level event model feeds an expected-event
// queue that one negedge process compares against every accepted spike.
module tb_encoder_scheduler;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int TS_W   = 5;
    localparam int WINDOW = 16;
    localparam int STEPS  = WINDOW * NUM_CH;
    localparam int N      = 10;
    localparam int M      = 5;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic [TS_W-1:0] ts;
    } ev_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [NUM_CH-1:0] input_bits;
    logic              busy;
    logic              done;
    logic              spike_valid;
    logic              spike_ready;
    logic [CH_W-1:0]   spike_ch;
    logic [TS_W-1:0]   spike_ts;

    encoder_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .input_bits (input_bits),
        .busy       (busy),
        .done       (done),
        .spike_valid(spike_valid),
        .spike_ready(spike_ready),
        .spike_ch   (spike_ch),
        .spike_ts   (spike_ts)
    );

    always #5 clk = ~clk;

    ev_t        exp_q[$];
    ev_t        mq[$];
    logic [3:0] m_lfsr;
    int         n_checks  = 0;
    int         n_pass    = 0;
    int         done_seen = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    function automatic logic [3:0] lfsr_step(input logic [3:0] l);
        return {l[2] ^ l[3], l[0], l[1], l[2]};
    endfunction

    // Enumerates the events of the first nsteps scan steps of a fresh frame.
    task automatic model(input logic [NUM_CH-1:0] b, input int nsteps,
                         inout logic [3:0] l, output bit last_hit);
        int cnt [NUM_CH];
        int thr;
        ev_t e;
        mq.delete();
        last_hit = 1'b0;
        foreach (cnt[i]) cnt[i] = 0;
        for (int s = 0; s < nsteps; s++) begin
            int c;
            int t;
            c = s % NUM_CH;
            t = s / NUM_CH;
            thr = (b[c] ? M : N) - 1 - int'(l[0]);
            last_hit = (cnt[c] >= thr);
            if (last_hit) begin
                e.ch = c[CH_W-1:0];
                e.ts = t[TS_W-1:0];
                mq.push_back(e);
                cnt[c] = 0;
            end else begin
                cnt[c]++;
            end
            if (c == NUM_CH - 1) l = lfsr_step(l);
        end
    endtask

    task automatic commit();
        foreach (mq[i]) exp_q.push_back(mq[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare process: accepted events, held-event stability, done pulse shape.
    logic hold_q = 1'b0;
    logic done_q = 1'b0;
    ev_t  hold_ev;
    ev_t  cmp_e;
    always @(negedge clk) begin
        if (!reset) begin
            if (hold_q) begin
                check("hold_valid", int'(spike_valid), 1);
                check("hold_ch", int'(spike_ch), int'(hold_ev.ch));
                check("hold_ts", int'(spike_ts), int'(hold_ev.ts));
            end
            if (spike_valid && spike_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 1, 0);
                end else begin
                    cmp_e = exp_q.pop_front();
                    check("event_ch", int'(spike_ch), int'(cmp_e.ch));
                    check("event_ts", int'(spike_ts), int'(cmp_e.ts));
                end
            end
            if (done) begin
                done_seen++;
                check("done_busy_low", int'(busy), 0);
                check("done_one_cycle", int'(done_q), 0);
            end
            hold_q     <= spike_valid && !spike_ready && !(abort && busy);
            hold_ev.ch <= spike_ch;
            hold_ev.ts <= spike_ts;
            done_q     <= done;
        end else begin
            hold_q <= 1'b0;
            done_q <= 1'b0;
        end
    end

    task automatic run_frame(input logic [NUM_CH-1:0] b, input int stall, input bit rnd,
                             input int exp_len, input int exp_first);
        bit hit;
        int t;
        int first_v;
        model(b, STEPS, m_lfsr, hit);
        commit();
        input_bits = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("frame_busy_rise", int'(busy), 1);
        t = 0;
        first_v = -1;
        while (!done && t < 2000) begin
            if (rnd) spike_ready = ($urandom_range(0, 2) != 0);
            tick();
            t++;
            if (spike_valid && first_v < 0) begin
                first_v = t;
                if (stall > 0) begin
                    spike_ready = 1'b0;
                    repeat (stall) begin
                        tick();
                        t++;
                    end
                    check("stall_busy", int'(busy), 1);
                    check("stall_valid", int'(spike_valid), 1);
                    spike_ready = 1'b1;
                end
            end
        end
        check("frame_done_seen", int'(done), 1);
        if (exp_len >= 0)   check("frame_len", t, exp_len);
        if (exp_first >= 0) check("first_event_cycle", first_v, exp_first);
    endtask

    task automatic drain();
        spike_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
        tick();
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_valid_low", int'(spike_valid), 0);
    endtask

    task automatic abort_frame();
        bit hit;
        int d0;
        // 20 steps complete five timesteps; the step-19 event is held and then discarded.
        model(4'b1111, 20, m_lfsr, hit);
        check("abort_model_last_hit", int'(hit), 1);
        if (hit) void'(mq.pop_back());
        commit();
        input_bits = 4'b1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (t == 10) begin
                start = 1'b1;
                input_bits = 4'b0000;
            end else begin
                start = 1'b0;
                input_bits = 4'b1111;
            end
            tick();
        end
        start = 1'b0;
        spike_ready = 1'b0;
        check("abort_pending_valid", int'(spike_valid), 1);
        check("abort_pending_ch", int'(spike_ch), 3);
        check("abort_pending_ts", int'(spike_ts), 4);
        d0 = done_seen;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        spike_ready = 1'b1;
        check("abort_busy_low", int'(busy), 0);
        check("abort_valid_cleared", int'(spike_valid), 0);
        repeat (5) tick();
        check("abort_no_done", done_seen, d0);
        check("abort_queue_empty", exp_q.size(), 0);
    endtask

    task automatic reset_mid();
        bit hit;
        logic [3:0] l;
        l = m_lfsr;
        model(4'b1111, STEPS, l, hit);
        commit();
        l = m_lfsr;
        model(4'b1111, 16, l, hit);
        input_bits = 4'b1111;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (16) tick();
        check("midreset_pending_valid", int'(spike_valid), int'(hit));
        reset = 1'b1;
        #2;
        check("midreset_pre_edge_busy", int'(busy), 1);
        check("midreset_pre_edge_valid", int'(spike_valid), int'(hit));
        tick();
        check("midreset_busy", int'(busy), 0);
        check("midreset_done", int'(done), 0);
        check("midreset_valid", int'(spike_valid), 0);
        check("midreset_ch", int'(spike_ch), 0);
        check("midreset_ts", int'(spike_ts), 0);
        exp_q.delete();
        m_lfsr = 4'b0001;
        reset = 1'b0;
        tick();
    endtask

    initial begin
        bit hit;
        logic [3:0] l;
        int d0;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        spike_ready = 1'b1;
        input_bits = '0;
        m_lfsr = 4'b0001;
        repeat (3) tick();
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_valid", int'(spike_valid), 0);
        check("reset_ch", int'(spike_ch), 0);
        check("reset_ts", int'(spike_ts), 0);
        reset = 1'b0;
        tick();

        // Hand-derived: LFSR bit 0 per timestep is 1,0,1,0 (period 4) from 0001.
        l = 4'b0001;
        model(4'b0001, STEPS, l, hit);
        check("pin_a_count", mq.size(), 6);
        check("pin_a_first_ch", int'(mq[0].ch), 0);
        check("pin_a_first_ts", int'(mq[0].ts), 4);
        check("pin_a_ts8_ch3", int'(mq[4].ch), 3);
        check("pin_a_last_ts", int'(mq[5].ts), 12);
        check("pin_a_lfsr_wrap", int'(l), 1);
        l = 4'b0100;
        model(4'b1111, STEPS, l, hit);
        check("pin_b_count", mq.size(), 16);
        check("pin_b_first_ts", int'(mq[0].ts), 3);
        check("pin_b_last_ts", int'(mq[15].ts), 15);

        run_frame(4'b0001, 0, 1'b0, 64, 17);
        drain();
        run_frame(4'b0001, 10, 1'b0, 74, 17);
        drain();

        d0 = done_seen;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle_busy", int'(busy), 0);
        tick();
        check("abort_idle_no_done", done_seen, d0);
        abort_frame();

        run_frame(4'b1111, 0, 1'b0, 64, -1);
        run_frame(4'b1111, 0, 1'b0, 64, -1);
        drain();

        for (int k = 0; k < 6; k++) begin
            run_frame(4'($urandom_range(0, 15)), 0, 1'b1, -1, -1);
        end
        drain();

        reset_mid();
        run_frame(4'b0001, 0, 1'b0, 64, 17);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
